// File: rtl/energy_meter_csr.sv
// energy_meter_csr: per-cycle energy accumulator with a CSR slave and tear-free 64-bit lo/hi readout.
// Define ENERGY_METER_PEAK_EN to add the windowed peak/last energy registers at 0x70/0x74.
module energy_meter_csr #(
  parameter int ACC_W      = 64,
  parameter int COST_W     = 16,
  parameter int WINDOW_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  dvfs_level,
  input  logic        core_active,
  input  logic        csr_valid,
  input  logic        csr_write,
  input  logic [7:0]  csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_ready,
  output logic [63:0] energy_count,
  output logic        energy_ovf
);

  localparam logic [7:0] ADDR_LO     = 8'h60;
  localparam logic [7:0] ADDR_HI     = 8'h64;
  localparam logic [7:0] ADDR_CTRL   = 8'h68;
  localparam logic [7:0] ADDR_STATUS = 8'h6C;

  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [ACC_W:0]           acc_sum;
  logic [31:0]              shadow_hi_q, shadow_hi_d;
  logic                     ovf_q, ovf_d;
  logic                     enable_q, enable_d;
  logic                     csr_ready_q, csr_ready_d;
  logic [31:0]              csr_rdata_q, csr_rdata_d;
  logic [31:0]              rd_mux;
  logic [3:0][COST_W-1:0]   dyn_cost_q, dyn_cost_d;
  logic [3:0][COST_W-1:0]   leak_cost_q, leak_cost_d;
  logic [COST_W-1:0]        inc_cost;
  logic                     accept, do_write, do_read, clear;
  logic                     unused_bits;

  // A request in the ready cycle is ignored, so a held valid cannot fire twice.
  assign accept   = csr_valid && !csr_ready_q;
  assign do_write = accept && csr_write;
  assign do_read  = accept && !csr_write;
  assign clear    = do_write && (csr_addr == ADDR_CTRL) && csr_wdata[1];
  assign inc_cost = core_active ? dyn_cost_q[dvfs_level] : leak_cost_q[dvfs_level];
  assign acc_sum  = {1'b0, acc_q} + (ACC_W+1)'(inc_cost);

  assign unused_bits = ^{csr_wdata[31:COST_W], (WINDOW_CYC > 0)};

`ifdef ENERGY_METER_PEAK_EN
  localparam int CNT_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;

  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [31:0]      win_sum_q, win_sum_d;
  logic [31:0]      peak_q, peak_d;
  logic [31:0]      last_q, last_d;
  logic [32:0]      win_add;
  logic [31:0]      win_next;

  // Window sum saturates instead of wrapping so a peak never looks smaller than it was.
  always_comb begin
    win_add   = {1'b0, win_sum_q} + 33'(enable_q ? inc_cost : '0);
    win_next  = win_add[32] ? 32'hFFFF_FFFF : win_add[31:0];
    win_cnt_d = win_cnt_q;
    win_sum_d = win_sum_q;
    peak_d    = peak_q;
    last_d    = last_q;
    if (clear) begin
      win_cnt_d = '0;
      win_sum_d = '0;
      peak_d    = '0;
      last_d    = '0;
    end else if (win_cnt_q == CNT_W'(WINDOW_CYC - 1)) begin
      last_d    = win_next;
      peak_d    = (win_next > peak_q) ? win_next : peak_q;
      win_sum_d = '0;
      win_cnt_d = '0;
    end else begin
      win_sum_d = win_next;
      win_cnt_d = win_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
      win_sum_q <= '0;
      peak_q    <= '0;
      last_q    <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      win_sum_q <= win_sum_d;
      peak_q    <= peak_d;
      last_q    <= last_d;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (csr_addr)
      ADDR_LO:     rd_mux = acc_q[31:0];
      ADDR_HI:     rd_mux = shadow_hi_q;
      ADDR_CTRL:   rd_mux = {31'b0, enable_q};
      ADDR_STATUS: rd_mux = {31'b0, ovf_q};
      8'h40, 8'h44, 8'h48, 8'h4C: rd_mux = 32'(dyn_cost_q[csr_addr[3:2]]);
      8'h50, 8'h54, 8'h58, 8'h5C: rd_mux = 32'(leak_cost_q[csr_addr[3:2]]);
`ifdef ENERGY_METER_PEAK_EN
      8'h70:       rd_mux = peak_q;
      8'h74:       rd_mux = last_q;
`endif
      default:     rd_mux = '0;
    endcase
  end

  // Clear wins over both the increment and the LO-read shadow capture.
  always_comb begin
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    shadow_hi_d  = shadow_hi_q;
    enable_d     = enable_q;
    dyn_cost_d   = dyn_cost_q;
    leak_cost_d  = leak_cost_q;
    csr_ready_d  = accept;
    csr_rdata_d  = do_read ? rd_mux : 32'h0;

    if (enable_q) begin
      acc_d = acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W]) ovf_d = 1'b1;
    end

    if (do_read && (csr_addr == ADDR_LO)) shadow_hi_d = acc_q[63:32];

    if (do_write) begin
      case (csr_addr)
        ADDR_CTRL: enable_d = csr_wdata[0];
        8'h40, 8'h44, 8'h48, 8'h4C: dyn_cost_d[csr_addr[3:2]]  = csr_wdata[COST_W-1:0];
        8'h50, 8'h54, 8'h58, 8'h5C: leak_cost_d[csr_addr[3:2]] = csr_wdata[COST_W-1:0];
        default: ;
      endcase
    end

    if (clear) begin
      acc_d       = '0;
      ovf_d       = 1'b0;
      shadow_hi_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '0;
      ovf_q          <= 1'b0;
      shadow_hi_q    <= '0;
      enable_q       <= 1'b1;
      csr_ready_q    <= 1'b0;
      csr_rdata_q    <= '0;
      dyn_cost_q[0]  <= COST_W'(4);
      dyn_cost_q[1]  <= COST_W'(8);
      dyn_cost_q[2]  <= COST_W'(16);
      dyn_cost_q[3]  <= COST_W'(32);
      leak_cost_q[0] <= COST_W'(1);
      leak_cost_q[1] <= COST_W'(1);
      leak_cost_q[2] <= COST_W'(2);
      leak_cost_q[3] <= COST_W'(4);
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      shadow_hi_q <= shadow_hi_d;
      enable_q    <= enable_d;
      csr_ready_q <= csr_ready_d;
      csr_rdata_q <= csr_rdata_d;
      dyn_cost_q  <= dyn_cost_d;
      leak_cost_q <= leak_cost_d;
    end
  end

  assign csr_ready    = csr_ready_q;
  assign csr_rdata    = csr_rdata_q;
  assign energy_count = acc_q;
  assign energy_ovf   = ovf_q;

endmodule
